// File: rtl/vecmac_pkg.sv
// rtl/vecmac_pkg.sv - shared widths and FSM state encoding for the dot-product sequencer
package vecmac_pkg;
  localparam int SUM_W = 18;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/vecmac_if.sv
// rtl/vecmac_if.sv - job, operand-read, tree-return and result signals of the sequencer
interface vecmac_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10,
  parameter int ACC_W  = 32
) ();
  import vecmac_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              dp_valid;
  logic              tree_out_valid;
  logic [SUM_W-1:0]  tree_sum;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              err;

  // master: host, operand memory and MAC pipeline; slave: the sequencer
  modport master (
    output start, base_addr, len, tree_out_valid, tree_sum, res_ready,
    input  busy, rd_en, rd_addr, dp_valid, res_valid, res_data, err
  );

  modport slave (
    input  start, base_addr, len, tree_out_valid, tree_sum, res_ready,
    output busy, rd_en, rd_addr, dp_valid, res_valid, res_data, err
  );
endinterface

// File: rtl/vecmac_vdelay.sv
// rtl/vecmac_vdelay.sv - 1-bit delay line of DEPTH cycles; a plain wire when DEPTH is 0
module vecmac_vdelay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else if (DEPTH == 1) begin : g_one
    logic sr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= 1'b0;
      else     sr <= d;
    end
    assign q = sr;
  end else begin : g_shift
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= {sr[DEPTH-2:0], d};
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vecmac_seq.sv
// rtl/vecmac_seq.sv - issues LEN operand-group reads, accumulates tree sums, returns the total
module vecmac_seq
  import vecmac_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10,
  parameter int ACC_W  = 32,
  parameter int RD_LAT = 1
) (
  input logic     clk,
  input logic     rst,
  vecmac_if.slave bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  ret_cnt;
  logic [ACC_W-1:0]  acc;
  logic              err_q;
  logic              rd_en_c;

  logic accept, in_job, ret_fire, ret_bad, last_issue, last_ret;

  assign accept     = (state_q == ST_IDLE) && bus.start;
  assign in_job     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  // A return is only legal while a job still owes beats; anything else is dropped.
  assign ret_fire   = bus.tree_out_valid && in_job && (ret_cnt != len_q);
  assign ret_bad    = bus.tree_out_valid && !ret_fire;
  assign last_issue = (issue_cnt == len_q - LEN_W'(1));
  assign last_ret   = ret_fire && (ret_cnt == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    rd_en_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = (bus.len == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_en_c = 1'b1;
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_ret) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      acc       <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q    <= bus.base_addr;
        len_q     <= bus.len;
        issue_cnt <= '0;
        ret_cnt   <= '0;
        acc       <= '0;
      end else begin
        if (rd_en_c) issue_cnt <= issue_cnt + LEN_W'(1);
        if (ret_fire) begin
          acc     <= acc + ACC_W'(bus.tree_sum);
          ret_cnt <= ret_cnt + LEN_W'(1);
        end
      end
      err_q <= (err_q && !accept) || ret_bad;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = rd_en_c ? (base_q + ADDR_W'(issue_cnt)) : '0;
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.res_data  = acc;
  assign bus.err       = err_q;

  vecmac_vdelay #(.DEPTH(RD_LAT)) u_vdelay (
    .clk (clk),
    .rst (rst),
    .d   (rd_en_c),
    .q   (bus.dp_valid)
  );
endmodule

// File: tb/tb_vecmac_seq.sv
// tb/tb_vecmac_seq.sv - directed bench: behavioural RAM, 4 multipliers and 2-stage adder tree
module tb_vecmac_seq;
  import vecmac_pkg::*;

  logic clk;
  logic rst;
  logic dp_clr;
  int   n_chk;
  int   n_fail;

  vecmac_if #(.ADDR_W(10), .LEN_W(10), .ACC_W(32)) bus ();

  vecmac_seq #(.ADDR_W(10), .LEN_W(10), .ACC_W(32), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [7:0]  mem_a [1024][LANES];
  logic signed [7:0]  mem_b [1024][LANES];
  logic signed [17:0] ra [LANES];
  logic signed [17:0] rb [LANES];
  logic signed [17:0] pr [LANES];
  logic               v1, v2;
  logic [17:0]        s2;
  logic               inj_v;
  logic [17:0]        inj_sum;

  // Datapath is deliberately not tied to rst so beats in flight survive a sequencer reset.
  always @(posedge clk) begin
    if (dp_clr) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (bus.rd_en) begin
        for (int l = 0; l < LANES; l++) begin
          ra[l] <= 18'(mem_a[bus.rd_addr][l]);
          rb[l] <= 18'(mem_b[bus.rd_addr][l]);
        end
      end
      v1 <= bus.dp_valid;
      for (int l = 0; l < LANES; l++) pr[l] <= ra[l] * rb[l];
      v2 <= v1;
      s2 <= pr[0] + pr[1] + pr[2] + pr[3];
    end
  end

  assign bus.tree_out_valid = v2 | inj_v;
  assign bus.tree_sum       = inj_v ? inj_sum : s2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input int addr, input int a, input int b);
    for (int l = 0; l < LANES; l++) begin
      mem_a[addr][l] = 8'(a);
      mem_b[addr][l] = 8'(b);
    end
  endtask

  task automatic do_job(input logic [9:0] b, input logic [9:0] l, input logic [31:0] exp,
                        input bit hs, input string tag);
    int   n, nrd;
    bit   got, prev;
    logic [9:0] ea;
    bus.base_addr = b;
    bus.len       = l;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    chk({tag, " err_cleared"}, 64'(bus.err), 64'd0);
    got = 1'b0; nrd = 0; prev = 1'b0; n = 0;
    for (int i = 1; i <= 400 && !got; i++) begin
      chk({tag, " dp_valid_delay"}, 64'(bus.dp_valid), 64'(prev));
      if (bus.rd_en) begin
        ea = b + 10'(nrd);
        chk({tag, " rd_addr"}, 64'(bus.rd_addr), 64'(ea));
        nrd++;
      end
      prev = bus.rd_en;
      if (bus.res_valid) begin
        got = 1'b1;
        n   = i;
      end else begin
        tick();
      end
    end
    chk({tag, " res_valid_seen"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(n), (l == 0) ? 64'd1 : 64'(l) + 64'd4);
    chk({tag, " reads"}, 64'(nrd), 64'(l));
    chk({tag, " res_data"}, 64'(bus.res_data), 64'(exp));
    if (hs) begin
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk({tag, " busy_after_hs"}, 64'(bus.busy), 64'd0);
      chk({tag, " res_valid_after_hs"}, 64'(bus.res_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    dp_clr = 1'b1;
    inj_v = 1'b0;
    inj_sum = '0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;
    bus.res_ready = 1'b0;
    for (int a = 0; a < 1024; a++) set_group(a, 0, 0);
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset rd_en", 64'(bus.rd_en), 64'd0);
    chk("reset rd_addr", 64'(bus.rd_addr), 64'd0);
    chk("reset dp_valid", 64'(bus.dp_valid), 64'd0);
    chk("reset res_valid", 64'(bus.res_valid), 64'd0);
    chk("reset res_data", 64'(bus.res_data), 64'd0);
    chk("reset err", 64'(bus.err), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    dp_clr = 1'b0;
    tick();

    // 1: four groups of 127*127 in every lane
    for (int a = 0; a < 4; a++) set_group(a, 127, 127);
    do_job(10'd0, 10'd4, 32'd258064, 1'b1, "t1");

    // 2: empty job
    do_job(10'd0, 10'd0, 32'd0, 1'b1, "t2");

    // 4: result held with ready low while start is pulsed
    set_group(10, 1, 1);
    set_group(11, 2, 3);
    do_job(10'd10, 10'd2, 32'd28, 1'b0, "t4");
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3);
      bus.len = 10'd5;
      bus.base_addr = 10'd0;
      tick();
      chk("t4 hold res_valid", 64'(bus.res_valid), 64'd1);
      chk("t4 hold res_data", 64'(bus.res_data), 64'd28);
      chk("t4 hold rd_en", 64'(bus.rd_en), 64'd0);
    end
    bus.start = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.res_ready = 1'b0;
    chk("t4 busy_after_hs", 64'(bus.busy), 64'd0);
    tick();
    chk("t4 start_ignored_busy", 64'(bus.busy), 64'd0);
    chk("t4 start_ignored_rd_en", 64'(bus.rd_en), 64'd0);
    set_group(20, 3, -2);
    do_job(10'd20, 10'd1, 32'd262120, 1'b1, "t4b");

    // 5: stray tree return in IDLE
    inj_v = 1'b1;
    inj_sum = 18'h3FFFF;
    tick();
    inj_v = 1'b0;
    chk("t5 err_set", 64'(bus.err), 64'd1);
    chk("t5 acc_unchanged", 64'(bus.res_data), 64'd262120);
    tick();
    chk("t5 err_sticky", 64'(bus.err), 64'd1);

    // 3: address wrap with mixed-sign lanes, accepted start clears err from t5
    for (int l = 0; l < LANES; l++) begin
      mem_a[10'h3FE][l] = 8'(l + 1);
      mem_b[10'h3FE][l] = 8'(l + 5);
    end
    set_group(10'h3FF, -1, 1);
    set_group(0, -128, -128);
    do_job(10'h3FE, 10'd3, 32'd327746, 1'b1, "t3");

    // 6: reset in the middle of a long job
    bus.base_addr = 10'd0;
    bus.len = 10'd100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    chk("t6 rd_en_mid_job", 64'(bus.rd_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6 rst busy", 64'(bus.busy), 64'd0);
    chk("t6 rst rd_en", 64'(bus.rd_en), 64'd0);
    chk("t6 rst rd_addr", 64'(bus.rd_addr), 64'd0);
    chk("t6 rst dp_valid", 64'(bus.dp_valid), 64'd0);
    chk("t6 rst res_valid", 64'(bus.res_valid), 64'd0);
    chk("t6 rst res_data", 64'(bus.res_data), 64'd0);
    chk("t6 rst err", 64'(bus.err), 64'd0);
    #2;
    rst = 1'b0;
    repeat (6) tick();
    chk("t6 stale_err", 64'(bus.err), 64'd1);
    chk("t6 idle_after_rst", 64'(bus.busy), 64'd0);
    for (int k = 0; k < 8; k++) begin
      for (int l = 0; l < LANES; l++) begin
        mem_a[100 + k][l] = 8'(l + 1);
        mem_b[100 + k][l] = 8'(k + 1);
      end
    end
    do_job(10'd100, 10'd8, 32'd360, 1'b1, "t6");
    chk("t6 err_final", 64'(bus.err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
